// File: rtl/muldiv_seq_if.sv
// Handshake and operand bundle between the execute stage and the RV32M
// multiply/divide sequencer.
interface muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            startE;
  logic [2:0]      funct3E;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic            killE;
  logic            busyE;
  logic            doneE;
  logic [XLEN-1:0] resultE;

  modport master (
    output startE, funct3E, SrcAE, SrcBE, killE,
    input  busyE, doneE, resultE
  );

  modport slave (
    input  startE, funct3E, SrcAE, SrcBE, killE,
    output busyE, doneE, resultE
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: 32-step shift-add multiply or
// restoring divide on operand magnitudes, sign applied on entry to DONE.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input logic         clk,
  input logic         reset,
  muldiv_seq_if.slave bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            state;
  logic [2:0]        f3;
  logic [XLEN-1:0]   ma;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     cnt;
  logic              neg_q;
  logic              neg_r;
  logic              busy;
  logic              done;
  logic [XLEN-1:0]   result;

  assign bus.busyE   = busy;
  assign bus.doneE   = done;
  assign bus.resultE = result;

  // Operand decode for a start request
  logic            signed_a, signed_b, sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_res;

  always_comb begin
    signed_a = !(bus.funct3E == 3'b011 || bus.funct3E == 3'b101 ||
                 bus.funct3E == 3'b111);
    signed_b = (bus.funct3E == 3'b000 || bus.funct3E == 3'b001 ||
                bus.funct3E == 3'b100 || bus.funct3E == 3'b110);
    sa       = signed_a & bus.SrcAE[XLEN-1];
    sb       = signed_b & bus.SrcBE[XLEN-1];
    mag_a    = sa ? -bus.SrcAE : bus.SrcAE;
    mag_b    = sb ? -bus.SrcBE : bus.SrcBE;
    div_zero = bus.funct3E[2] && (bus.SrcBE == '0);
    div_ovf  = bus.funct3E[2] && !bus.funct3E[0] &&
               (bus.SrcAE == {1'b1, {(XLEN-1){1'b0}}}) && (bus.SrcBE == '1);
    if (div_zero)
      special_res = bus.funct3E[1] ? bus.SrcAE : '1;
    else
      special_res = bus.funct3E[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // One iteration of each datapath; acc holds {high/remainder, low/quotient}
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_sh, div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mul_res, div_res, quo, rem;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, ma} : '0);
    mul_next = {mul_sum, acc[XLEN-1:1]};
    div_sh   = acc[2*XLEN-1:XLEN-1];
    div_diff = div_sh - {1'b0, ma};
    if (div_diff[XLEN])
      div_next = {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else
      div_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    prod    = neg_q ? -mul_next : mul_next;
    mul_res = (f3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    quo     = div_next[XLEN-1:0];
    rem     = div_next[2*XLEN-1:XLEN];
    if (f3[1])
      div_res = neg_r ? -rem : rem;
    else
      div_res = neg_q ? -quo : quo;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      f3     <= '0;
      ma     <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else if (bus.killE) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.startE) begin
            f3    <= bus.funct3E;
            neg_q <= sa ^ sb;
            neg_r <= sa;
            cnt   <= CW'(XLEN-1);
            if (div_zero || div_ovf) begin
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              result <= special_res;
            end else if (bus.funct3E[2]) begin
              ma    <= mag_b;
              acc   <= {{XLEN{1'b0}}, mag_a};
              state <= DIV;
              busy  <= 1'b1;
            end else begin
              ma    <= mag_a;
              acc   <= {{XLEN{1'b0}}, mag_b};
              state <= MUL;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        MUL, DIV: begin
          acc <= (state == MUL) ? mul_next : div_next;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= (state == MUL) ? mul_res : div_res;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq: timing, signed/unsigned
// results, special-case divides, kill, ignored starts, back-to-back, reset.
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  muldiv_seq_if #(.XLEN(32)) bus ();

  muldiv_seq #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.startE  = 1'b1;
    bus.funct3E = f3;
    bus.SrcAE   = a;
    bus.SrcBE   = b;
    @(posedge clk);
    #1 bus.startE = 1'b0;
  endtask

  // Observes cycles after an accepted start; done_cyc stays -1 if no done within 60 cycles.
  task automatic wait_done(output int busy_cnt, output int done_cyc, output logic [31:0] res);
    busy_cnt = 0;
    done_cyc = -1;
    res      = 'x;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bus.busyE === 1'b1) busy_cnt++;
      if (bus.doneE === 1'b1) begin
        done_cyc = c;
        res      = bus.resultE;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.busyE, bus.doneE, bus.resultE} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b result=%h, want 0/0/0",
               bus.busyE, bus.doneE, bus.resultE);
    end
    reset = 1'b1;
  endtask

  task automatic test_mul;
    int bc, dc;
    logic [31:0] r;
    issue(3'b000, 32'd7, 32'hFFFF_FFFD);
    wait_done(bc, dc, r);
    n_checks++;
    if (bc !== 32 || dc !== 33) begin
      n_fail++;
      $display("FAIL mul_timing: busy_cycles=%0d done_cycle=%0d, want 32/33", bc, dc);
    end
    n_checks++;
    if (r !== 32'hFFFF_FFEB) begin
      n_fail++;
      $display("FAIL mul_result: got %h, want FFFFFFEB", r);
    end
    @(negedge clk);
    n_checks++;
    if (bus.doneE !== 1'b0 || bus.resultE !== 32'hFFFF_FFEB) begin
      n_fail++;
      $display("FAIL mul_done_pulse: done=%b result=%h, want 0/FFFFFFEB", bus.doneE, bus.resultE);
    end
  endtask

  task automatic test_mul_high;
    logic [2:0]  f3  [3] = '{3'b001, 3'b010, 3'b011};
    logic [31:0] a   [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] b   [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [3] = '{32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    int bc, dc;
    logic [31:0] r;
    for (int i = 0; i < 3; i++) begin
      issue(f3[i], a[i], b[i]);
      wait_done(bc, dc, r);
      n_checks++;
      if (dc !== 33 || r !== exp[i]) begin
        n_fail++;
        $display("FAIL mul_high[%0d]: done_cycle=%0d result=%h, want 33/%h", i, dc, r, exp[i]);
      end
    end
  endtask

  task automatic test_div;
    logic [2:0]  f3  [3] = '{3'b100, 3'b110, 3'b101};
    logic [31:0] a   [3] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
    logic [31:0] b   [3] = '{32'd2, 32'd2, 32'd2};
    logic [31:0] exp [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC};
    int bc, dc;
    logic [31:0] r;
    for (int i = 0; i < 3; i++) begin
      issue(f3[i], a[i], b[i]);
      wait_done(bc, dc, r);
      n_checks++;
      if (bc !== 32 || dc !== 33 || r !== exp[i]) begin
        n_fail++;
        $display("FAIL div[%0d]: busy=%0d done_cycle=%0d result=%h, want 32/33/%h",
                 i, bc, dc, r, exp[i]);
      end
    end
  endtask

  task automatic test_special;
    logic [2:0]  f3  [4] = '{3'b100, 3'b111, 3'b100, 3'b110};
    logic [31:0] a   [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] b   [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int bc, dc;
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      issue(f3[i], a[i], b[i]);
      wait_done(bc, dc, r);
      n_checks++;
      if (bc !== 0 || dc !== 1 || r !== exp[i]) begin
        n_fail++;
        $display("FAIL special[%0d]: busy=%0d done_cycle=%0d result=%h, want 0/1/%h",
                 i, bc, dc, r, exp[i]);
      end
    end
  endtask

  task automatic test_kill;
    int bc, dc;
    logic [31:0] r;
    issue(3'b000, 32'd3, 32'd5);
    wait_done(bc, dc, r);
    n_checks++;
    if (r !== 32'd15) begin
      n_fail++;
      $display("FAIL kill_setup: result=%h, want 0000000f", r);
    end
    issue(3'b000, 32'd7, 32'd9);
    repeat (9) @(posedge clk);
    #1 bus.killE = 1'b1;
    @(posedge clk);
    #1 bus.killE = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.busyE !== 1'b0 || bus.doneE !== 1'b0) begin
      n_fail++;
      $display("FAIL kill_idle: busy=%b done=%b, want 0/0", bus.busyE, bus.doneE);
    end
    wait_done(bc, dc, r);
    n_checks++;
    if (dc !== -1 || bus.resultE !== 32'd15) begin
      n_fail++;
      $display("FAIL kill_no_done: done_cycle=%0d result=%h, want none/0000000f", dc, bus.resultE);
    end
    @(negedge clk);
    bus.startE = 1'b1;
    bus.killE  = 1'b1;
    bus.funct3E = 3'b000;
    bus.SrcAE  = 32'd2;
    bus.SrcBE  = 32'd2;
    @(posedge clk);
    #1 begin bus.startE = 1'b0; bus.killE = 1'b0; end
    @(negedge clk);
    n_checks++;
    if (bus.busyE !== 1'b0 || bus.doneE !== 1'b0) begin
      n_fail++;
      $display("FAIL start_kill_collision: busy=%b done=%b, want 0/0", bus.busyE, bus.doneE);
    end
    issue(3'b000, 32'd6, 32'd7);
    wait_done(bc, dc, r);
    n_checks++;
    if (bc !== 32 || dc !== 33 || r !== 32'd42) begin
      n_fail++;
      $display("FAIL after_kill: busy=%0d done_cycle=%0d result=%h, want 32/33/0000002a", bc, dc, r);
    end
  endtask

  task automatic test_start_ignored;
    int bc;
    bc = 0;
    issue(3'b011, 32'h0001_0000, 32'h0001_0000);
    bus.startE  = 1'b1;
    bus.funct3E = 3'b100;
    bus.SrcAE   = 32'd5;
    bus.SrcBE   = 32'd0;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      if (bus.busyE === 1'b1 && bus.doneE === 1'b0) bc++;
      if (c == 32) bus.startE = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if (bc !== 32 || bus.doneE !== 1'b1 || bus.resultE !== 32'd1) begin
      n_fail++;
      $display("FAIL start_ignored: busy=%0d done=%b result=%h, want 32/1/00000001",
               bc, bus.doneE, bus.resultE);
    end
  endtask

  task automatic test_back_to_back;
    int bc, dc;
    logic [31:0] r;
    issue(3'b101, 32'd100, 32'd7);
    dc = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bus.doneE === 1'b1) begin
        dc = c;
        break;
      end
    end
    n_checks++;
    if (dc !== 33 || bus.resultE !== 32'd14) begin
      n_fail++;
      $display("FAIL b2b_first: done_cycle=%0d result=%h, want 33/0000000e", dc, bus.resultE);
    end
    bus.startE  = 1'b1;
    bus.funct3E = 3'b111;
    bus.SrcAE   = 32'd100;
    bus.SrcBE   = 32'd7;
    @(posedge clk);
    #1 bus.startE = 1'b0;
    wait_done(bc, dc, r);
    n_checks++;
    if (bc !== 32 || dc !== 33 || r !== 32'd2) begin
      n_fail++;
      $display("FAIL b2b_second: busy=%0d done_cycle=%0d result=%h, want 32/33/00000002", bc, dc, r);
    end
  endtask

  task automatic test_reset_mid;
    int bc, dc;
    logic [31:0] r;
    issue(3'b100, 32'd100, 32'd3);
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.busyE, bus.doneE, bus.resultE} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b result=%h, want 0/0/0",
               bus.busyE, bus.doneE, bus.resultE);
    end
    wait_done(bc, dc, r);
    n_checks++;
    if (dc !== -1 || bc !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_lost: busy=%0d done_cycle=%0d, want 0/none", bc, dc);
    end
  endtask

  initial begin
    bus.startE  = 1'b0;
    bus.killE   = 1'b0;
    bus.funct3E = '0;
    bus.SrcAE   = '0;
    bus.SrcBE   = '0;
    test_reset;
    test_mul;
    test_mul_high;
    test_div;
    test_special;
    test_kill;
    test_start_ignored;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative sequencer for the RV32M multiply/divide instructions. It sits beside the execute-stage ALU and takes the same forwarded operands, SrcAE and SrcBE. It runs a 32-step shift-add multiplier or restoring divider and holds the pipeline via `busyE` until the result is ready. One operation is in flight at a time, and the block carries its own state machine.

## Interface
Parameters:
- `XLEN`, 32: operand/result width; only 32 is supported.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset (0 = reset, sampled on posedge `clk`).
- `startE`  in  1  request a new operation this cycle.
- `funct3E`  in  3  RV32M op: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
- `SrcAE`  in  32  rs1 operand (dividend / multiplicand).
- `SrcBE`  in  32  rs2 operand (divisor / multiplier).
- `killE`  in  1  abort the in-flight operation (branch flush / trap).
- `busyE`  out  1  operation in progress; pipeline must stall.
- `doneE`  out  1  one-cycle pulse; `resultE` is valid.
- `resultE`  out  32  result; held until the next accepted start.

## Operation
- States: IDLE, MUL, DIV, DONE.
- Reset (`reset`=0): state IDLE; `busyE`=0, `doneE`=0, `resultE`=0; all internal registers cleared.
- Accept: `startE`=1 while state is IDLE or DONE and `killE`=0.
  - On acceptance, latch `funct3E`, operand magnitudes and result sign.
  - Load iteration counter with 31.
  - Go to MUL (funct3[2]=0) or DIV (funct3[2]=1).
- `startE` while in MUL/DIV: ignored (not queued).
- Signedness:
  - mul/mulh: both operands signed.
  - mulhsu: rs1 signed, rs2 unsigned.
  - mulhu/divu/remu: unsigned.
  - div/rem: signed.
  - Signed operands are converted to magnitudes; the core iterates unsigned; the sign is applied in DONE via two's complement.
- MUL:
  - 64-bit accumulator; each cycle add the multiplicand if the current multiplier bit is 1, then shift.
  - After 32 iterations, apply the sign to the 64-bit product.
  - mul returns bits [31:0]; mulh/mulhsu/mulhu return bits [63:32].
- DIV: restoring division, one quotient bit per cycle, 32 cycles.
  - Quotient sign = sign(rs1) XOR sign(rs2).
  - Remainder sign = sign(rs1).
- Special cases, detected at acceptance; skip MUL/DIV and go directly to DONE:
  - Divide by zero: div/divu → 0xFFFFFFFF; rem/remu → rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF) for div → 0x80000000; for rem → 0.
- DONE: `doneE`=1 and `resultE` updated for exactly this cycle.
  - Next state is IDLE, or MUL/DIV if a new start is accepted in the same cycle.
- `killE`=1 in any state → IDLE next edge; `doneE` stays 0; `resultE` unchanged. Kill has priority over a simultaneous start.
- Width rules: all arithmetic is modulo 2^32 on results. Accumulator and remainder datapaths are 64 and 33 bits, with no overflow loss.

## Timing
- Start accepted at edge N. `busyE`=1 during cycles N+1..N+32 (MUL/DIV). `doneE`=1 during cycle N+33. `busyE`=0 in DONE.
- Special-case divides: `doneE`=1 during cycle N+1; `busyE` never asserted.
- `busyE` and `doneE` are registered (decoded from state), with no combinational path from inputs.
- `resultE` is registered: it changes only on entry to DONE or on reset.
- Back-to-back: a start in the DONE cycle is accepted, and `busyE` rises the following cycle.
- Reset asserted mid-operation → all outputs at reset values at the next edge; the operation is lost.

## Test plan
- mul, SrcAE=7, SrcBE=0xFFFFFFFD (start at edge N) → `busyE` high N+1..N+32; `doneE` at N+33; `resultE`=0xFFFFFFEB.
- mulh 0x80000000×0x80000000 → 0x40000000. mulhsu 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF. mulhu 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- div −7/2 → 0xFFFFFFFD; rem −7%2 → 0xFFFFFFFF; divu 0xFFFFFFF9/2 → 0x7FFFFFFC. All at N+33.
- div 5/0 → 0xFFFFFFFF and remu 5/0 → 5, with `doneE` at N+1 and `busyE` never high. div 0x80000000/0xFFFFFFFF → 0x80000000; rem of the same operands → 0.
- Kill and start collisions:
  - Start mul, assert `killE` at cycle N+10 → state IDLE at N+11; no `doneE`; `resultE` retains its prior value.
  - `startE`+`killE` together → not accepted.
  - New start at N+12 completes normally at N+45.
- `reset`=0 at cycle N+5 of a div → `busyE`/`doneE`/`resultE`=0 next edge; `startE` held during cycles N+1..N+32 of an op has no effect; a start in the DONE cycle yields a back-to-back result 33 cycles later.
